// File: rtl/led_seq_pkg.sv
// Shared mode encodings, LED constants and the step-indexed pattern table
// for led_mode_sequencer.
package led_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT_L = 3'd1,
    SHIFT_R = 3'd2,
    BLINK   = 3'd3,
    ON      = 3'd4
  } mode_e;

  localparam logic [3:0] LED_OFF = 4'b0000;
  localparam logic [3:0] LED_ALL = 4'b1111;

  function automatic logic [3:0] led_pattern(input mode_e m, input logic [1:0] step);
    logic [3:0] pat;
    pat = LED_OFF;
    case (m)
      SHIFT_L: pat = 4'b0001 << step;
      SHIFT_R: pat = 4'b1000 >> step;
      BLINK:   pat = step[0] ? LED_OFF : LED_ALL;
      ON:      pat = LED_ALL;
      default: pat = LED_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low key: 2-FF synchronizer, stability-count debouncer and a
// one-cycle press pulse on the debounced 1->0 transition.
module key_debounce
  import led_seq_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_level,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= key_in;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Any cycle agreeing with the accepted level restarts the stability window.
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign key_level = r_level;
  assign press     = r_level_d & ~r_level;

endmodule

// File: rtl/led_mode_sequencer.sv
// Debounced four-key mode selector driving stepped LED patterns.
// Optional LED_SEQ_AUTO_OFF_EN returns to IDLE after AUTO_OFF_STEPS advances.
module led_mode_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned TICK_CYCLES    = 10_000_000,
  parameter int unsigned DEB_CYCLES     = 1_000_000,
  parameter int unsigned AUTO_OFF_STEPS = 32
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] key,
  output logic [3:0] led,
  output logic [2:0] mode,
  output logic       step_tick
);

  localparam int unsigned TICK_W = $clog2(TICK_CYCLES);

  if (TICK_CYCLES < 2) begin : g_bad_tick
    $error("TICK_CYCLES must be at least 2");
  end
  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("DEB_CYCLES must be at least 2");
  end
  if (AUTO_OFF_STEPS < 1 || AUTO_OFF_STEPS > 255) begin : g_bad_auto_off
    $error("AUTO_OFF_STEPS must be in 1..255");
  end

  logic [3:0]        w_level;
  logic [3:0]        w_press;
  logic [3:0]        w_event;
  logic              w_any;
  mode_e             w_sel;
  mode_e             w_next_mode;
  logic              w_tick_end;
  logic              w_timeout;
  logic [1:0]        w_step_next;

  mode_e             r_mode;
  logic [1:0]        r_step;
  logic [TICK_W-1:0] r_tick;
  logic [3:0]        r_led;
  logic              r_step_tick;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .key_in   (key[i]),
      .key_level(w_level[i]),
      .press    (w_press[i])
    );
  end

  assign w_event = w_press & ~w_level;
  assign w_any   = |w_event;

  always_comb begin
    w_sel = IDLE;
    if (w_event[0])      w_sel = SHIFT_L;
    else if (w_event[1]) w_sel = SHIFT_R;
    else if (w_event[2]) w_sel = BLINK;
    else if (w_event[3]) w_sel = ON;
  end

  assign w_next_mode = (w_sel == r_mode) ? IDLE : w_sel;
  assign w_tick_end  = (r_tick == TICK_W'(TICK_CYCLES - 1));
  assign w_step_next = r_step + 2'd1;

`ifdef LED_SEQ_AUTO_OFF_EN
  logic [7:0] r_run;

  assign w_timeout = (r_run == 8'(AUTO_OFF_STEPS - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst || w_any || r_mode == IDLE) begin
      r_run <= '0;
    end else if (w_tick_end) begin
      r_run <= w_timeout ? 8'd0 : r_run + 8'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_mode      <= IDLE;
      r_step      <= '0;
      r_tick      <= '0;
      r_led       <= LED_OFF;
      r_step_tick <= 1'b0;
    end else if (w_any) begin
      // A press beats a coincident terminal tick: restart at step 0, no pulse.
      r_mode      <= w_next_mode;
      r_step      <= '0;
      r_tick      <= '0;
      r_led       <= led_pattern(w_next_mode, 2'd0);
      r_step_tick <= 1'b0;
    end else if (r_mode != IDLE) begin
      if (w_tick_end) begin
        r_tick <= '0;
        if (w_timeout) begin
          r_mode      <= IDLE;
          r_step      <= '0;
          r_led       <= LED_OFF;
          r_step_tick <= 1'b0;
        end else begin
          r_step      <= w_step_next;
          r_led       <= led_pattern(r_mode, w_step_next);
          r_step_tick <= 1'b1;
        end
      end else begin
        r_tick      <= r_tick + 1'b1;
        r_step_tick <= 1'b0;
      end
    end else begin
      r_tick      <= '0;
      r_step_tick <= 1'b0;
    end
  end

  assign led       = r_led;
  assign mode      = r_mode;
  assign step_tick = r_step_tick;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Randomized scoreboard bench for led_mode_sequencer (TICK=8, DEB=4, AUTO_OFF=3).
module tb_led_mode_sequencer;

  localparam int TICK = 8;
  localparam int DEB  = 4;
  localparam int AUTO = 3;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [3:0] key     = 4'hF;
  logic [3:0] led;
  logic [2:0] mode;
  logic       step_tick;

  led_mode_sequencer #(
    .TICK_CYCLES   (TICK),
    .DEB_CYCLES    (DEB),
    .AUTO_OFF_STEPS(AUTO)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .key      (key),
    .led      (led),
    .mode     (mode),
    .step_tick(step_tick)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit done   = 1'b0;

  logic [7:0] exp_q[$];

  // Reference model: keys seen through a two-sample delay line, accepted after
  // DEB consecutive disagreeing samples; display derived from time in mode.
  logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF, m_level = 4'hF, m_fell = 4'h0;
  logic [3:0] m_hist[$];
  int         m_mode = 0;
  int         m_age  = 0;

  function automatic logic [3:0] model_led(input int md, input int age);
    int step;
    logic [3:0] sl[4];
    sl   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    step = (age / TICK) % 4;
    case (md)
      1:       return sl[step];
      2:       return sl[3 - step];
      3:       return (step % 2 == 0) ? 4'b1111 : 4'b0000;
      4:       return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  always @(posedge sys_clk) begin
    logic [3:0] ev;
    logic       st;
    bit         stable;
    int         sel;
    int         nm;
    cycle++;
    if (sys_rst) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_level = 4'hF; m_fell = 4'h0;
      m_hist.delete();
      m_mode = 0; m_age = 0;
    end else begin
      ev = m_fell;
      m_hist.push_back(m_s2);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      m_s2 = m_s1;
      m_s1 = key;
      m_fell = 4'h0;
      if (m_hist.size() == DEB) begin
        for (int b = 0; b < 4; b++) begin
          stable = 1'b1;
          foreach (m_hist[j]) if (m_hist[j][b] == m_level[b]) stable = 1'b0;
          if (stable) begin
            if (m_level[b]) m_fell[b] = 1'b1;
            m_level[b] = ~m_level[b];
          end
        end
      end
      sel = -1;
      for (int b = 3; b >= 0; b--) if (ev[b]) sel = b;
      if (sel >= 0) begin
        nm     = sel + 1;
        m_mode = (nm == m_mode) ? 0 : nm;
        m_age  = 0;
      end else if (m_mode != 0) begin
        m_age++;
`ifdef LED_SEQ_AUTO_OFF_EN
        if (m_age == AUTO * TICK) m_mode = 0;
`endif
      end
    end
    st = (m_mode != 0) && (m_age != 0) && (m_age % TICK == 0);
    exp_q.push_back({model_led(m_mode, m_age), 3'(m_mode), st});
  end

  initial begin
    logic [7:0] e;
    while (!done) begin
      @(posedge sys_clk);
      #2;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty cycle %0d: no expected entry", cycle);
      end else begin
        e = exp_q.pop_front();
        if ({led, mode, step_tick} !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: led %b mode %0d tick %b, expected led %b mode %0d tick %b",
                   cycle, led, mode, step_tick, e[7:4], e[3:1], e[0]);
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic hold(input logic [3:0] k, input int n);
    key = k;
    cycles(n);
  endtask

  initial begin
    sys_rst = 1'b1;
    key     = 4'hF;
    cycles(3);
    sys_rst = 1'b0;
    cycles(50);
    // chatter, then a real press of key0 and a few steps of SHIFT_L
    hold(4'hE, 3);  hold(4'hF, 10);
    hold(4'hE, 10); hold(4'hF, 45);
    // toggle back to IDLE
    hold(4'hE, 8);  hold(4'hF, 30);
    // simultaneous key1 + key2
    hold(4'h9, 8);  hold(4'hF, 30);
    // sweep press timing against the step tick, alternating BLINK and ON
    for (int j = 0; j < 16; j++) begin
      hold((j % 2 == 0) ? 4'hB : 4'h7, 6);
      hold(4'hF, 20 + j);
    end
    // reset mid-pattern
    hold(4'hE, 8); hold(4'hF, 13);
    sys_rst = 1'b1; cycles(1); sys_rst = 1'b0;
    cycles(20);
    // ON mode: times out with auto-off, otherwise persists
    hold(4'h7, 8); hold(4'hF, 100);
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 59) == 0) begin
        sys_rst = 1'b1; cycles(1); sys_rst = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) hold(4'hF, $urandom_range(1, 30));
      else hold(4'($urandom_range(0, 15)), $urandom_range(1, 12));
    end
    hold(4'hF, 10);
    done = 1'b1;
  end

endmodule
